// File: rtl/glitch_free_clock_divmux_if.sv
// Control and status bundle for glitch_free_clock_divmux.
// master drives the run/select/divisor requests; slave is the clock generator.
interface glitch_free_clock_divmux_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned SEL_WIDTH = $clog2(CHANNELS)
);
  logic                          en;
  logic [SEL_WIDTH-1:0]          sel;
  logic [CHANNELS*DIV_WIDTH-1:0] div_flat;
  logic                          clk_out;
  logic                          rise_stb;
  logic                          fall_stb;
  logic [SEL_WIDTH-1:0]          active_sel;
  logic                          running;
  logic                          pending;

  modport master (
    output en, sel, div_flat,
    input  clk_out, rise_stb, fall_stb, active_sel, running, pending
  );

  modport slave (
    input  en, sel, div_flat,
    output clk_out, rise_stb, fall_stb, active_sel, running, pending
  );
endinterface

// File: rtl/glitch_free_clock_divmux.sv
// Glitch-free 50%-duty clock divider with runtime channel/divisor selection.
// Ratio, start and stop changes are applied only at the end of a LOW phase.
module glitch_free_clock_divmux #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned SEL_WIDTH = $clog2(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst,
  glitch_free_clock_divmux_if.slave   bus
);

  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_HIGH    = 2'd1,
    ST_LOW     = 2'd2
  } state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_active_div;
  logic [SEL_WIDTH-1:0] r_active_sel;
  logic                 r_clk_out;
  logic                 r_rise_stb;
  logic                 r_fall_stb;
  logic                 r_running;

  state_t               w_nxt_state;
  logic [DIV_WIDTH-1:0] w_nxt_cnt;
  logic [DIV_WIDTH-1:0] w_nxt_div;
  logic [SEL_WIDTH-1:0] w_nxt_sel;
  logic                 w_nxt_clk;
  logic                 w_nxt_rise;
  logic                 w_nxt_fall;

  logic [DIV_WIDTH-1:0] w_div_arr [CHANNELS];
  logic [SEL_WIDTH-1:0] w_sel_clamp;
  logic [DIV_WIDTH-1:0] w_sel_div;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_div_unpack
    assign w_div_arr[gi] = bus.div_flat[gi*DIV_WIDTH +: DIV_WIDTH];
  end

  assign w_sel_clamp = (bus.sel > MAX_SEL) ? MAX_SEL : bus.sel;
  assign w_sel_div   = w_div_arr[w_sel_clamp];

  // Next-state and next-output logic; a new HIGH phase is the only place settings are latched
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_div   = r_active_div;
    w_nxt_sel   = r_active_sel;
    w_nxt_clk   = r_clk_out;
    w_nxt_rise  = 1'b0;
    w_nxt_fall  = 1'b0;

    case (r_state)
      ST_STOPPED: begin
        w_nxt_clk = 1'b0;
        if (bus.en) begin
          w_nxt_state = ST_HIGH;
          w_nxt_sel   = w_sel_clamp;
          w_nxt_div   = w_sel_div;
          w_nxt_cnt   = '0;
          w_nxt_clk   = 1'b1;
          w_nxt_rise  = 1'b1;
        end
      end

      ST_HIGH: begin
        if (r_cnt == r_active_div) begin
          w_nxt_state = ST_LOW;
          w_nxt_cnt   = '0;
          w_nxt_clk   = 1'b0;
          w_nxt_fall  = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + DIV_WIDTH'(1);
        end
      end

      ST_LOW: begin
        if (r_cnt != r_active_div) begin
          w_nxt_cnt = r_cnt + DIV_WIDTH'(1);
        end else if (bus.en) begin
          w_nxt_state = ST_HIGH;
          w_nxt_sel   = w_sel_clamp;
          w_nxt_div   = w_sel_div;
          w_nxt_cnt   = '0;
          w_nxt_clk   = 1'b1;
          w_nxt_rise  = 1'b1;
        end else begin
          w_nxt_state = ST_STOPPED;
          w_nxt_clk   = 1'b0;
        end
      end

      default: begin
        w_nxt_state = ST_STOPPED;
        w_nxt_clk   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_STOPPED;
      r_cnt        <= '0;
      r_active_div <= '0;
      r_active_sel <= '0;
      r_clk_out    <= 1'b0;
      r_rise_stb   <= 1'b0;
      r_fall_stb   <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_active_div <= w_nxt_div;
      r_active_sel <= w_nxt_sel;
      r_clk_out    <= w_nxt_clk;
      r_rise_stb   <= w_nxt_rise;
      r_fall_stb   <= w_nxt_fall;
      r_running    <= (w_nxt_state != ST_STOPPED);
    end
  end

  assign bus.clk_out    = r_clk_out;
  assign bus.rise_stb   = r_rise_stb;
  assign bus.fall_stb   = r_fall_stb;
  assign bus.active_sel = r_active_sel;
  assign bus.running    = r_running;
  // A start, stop or channel change has been requested but not yet taken
  assign bus.pending    = (bus.en & ~r_running) | (~bus.en & r_running) |
                          (r_running & (w_sel_clamp != r_active_sel));

endmodule

// File: tb/tb_glitch_free_clock_divmux.sv
// Bench for glitch_free_clock_divmux: directed scenarios then random traffic,
// compared every cycle against a phase-countdown model of the divider.
module tb_glitch_free_clock_divmux;

  localparam int unsigned CH = 3;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;

  glitch_free_clock_divmux_if #(.CHANNELS(CH), .DIV_WIDTH(DW)) bus ();

  glitch_free_clock_divmux #(.CHANNELS(CH), .DIV_WIDTH(DW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: run flag, phase level, cycles left in the phase, latched channel/divisor
  bit m_run, m_hi, m_clk, m_rise, m_fall;
  int m_left, m_sel, m_div;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int clampf(input int s);
    return (s > int'(CH) - 1) ? int'(CH) - 1 : s;
  endfunction

  task automatic set_div(input int ch, input int v);
    bus.div_flat[ch*DW +: DW] = DW'(v);
  endtask

  task automatic model_start();
    m_sel  = clampf(int'(bus.sel));
    m_div  = int'(bus.div_flat[m_sel*DW +: DW]);
    m_run  = 1'b1;
    m_hi   = 1'b1;
    m_clk  = 1'b1;
    m_rise = 1'b1;
    m_left = m_div;
  endtask

  task automatic model_step();
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_hi = 1'b0; m_clk = 1'b0;
      m_left = 0; m_sel = 0; m_div = 0;
    end else if (!m_run) begin
      if (bus.en) model_start();
    end else if (m_left != 0) begin
      m_left--;
    end else if (m_hi) begin
      m_hi   = 1'b0;
      m_clk  = 1'b0;
      m_fall = 1'b1;
      m_left = m_div;
    end else if (bus.en) begin
      model_start();
    end else begin
      m_run = 1'b0;
      m_clk = 1'b0;
    end
  endtask

  // One clock: model advances on the rising edge, outputs checked on the falling edge
  task automatic cycle();
    bit exp_pend;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_pend = (bus.en && !m_run) || (!bus.en && m_run) ||
               (m_run && clampf(int'(bus.sel)) != m_sel);
    chk("clk_out",    32'(bus.clk_out),    32'(m_clk));
    chk("rise_stb",   32'(bus.rise_stb),   32'(m_rise));
    chk("fall_stb",   32'(bus.fall_stb),   32'(m_fall));
    chk("active_sel", 32'(bus.active_sel), 32'(m_sel));
    chk("running",    32'(bus.running),    32'(m_run));
    chk("pending",    32'(bus.pending),    32'(exp_pend));
  endtask

  // Length of the next clk_out phase at the given level, counted on the DUT itself
  task automatic measure(input logic level, input int exp_len, input string tag);
    int len   = 0;
    int guard = 0;
    while (bus.clk_out !== level && guard < 200) begin
      cycle();
      guard++;
    end
    while (bus.clk_out === level && bus.running === 1'b1 && len < 200) begin
      len++;
      cycle();
    end
    chk(tag, 32'(len), 32'(exp_len));
  endtask

  initial begin
    m_run = 1'b0; m_hi = 1'b0; m_clk = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    m_left = 0; m_sel = 0; m_div = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.sel = '0;
    bus.div_flat = '0;
    set_div(0, 2);

    // Reset held three cycles, then start on channel 0 with div=2
    repeat (3) cycle();
    rst = 1'b0;
    bus.en = 1'b1;
    cycle();
    chk("start_rise", 32'(bus.rise_stb), 32'd1);
    measure(1'b1, 3, "start_hi0");
    measure(1'b0, 3, "start_lo0");
    measure(1'b1, 3, "start_hi1");
    measure(1'b0, 3, "start_lo1");

    // Channel switch: ch0 div1 -> ch1 div4, requested mid-HIGH
    set_div(0, 1);
    set_div(1, 4);
    measure(1'b1, 3, "sw_old_hi");
    measure(1'b0, 3, "sw_old_lo");
    bus.sel = 2'd1;
    #1;
    chk("sw_pending", 32'(bus.pending), 32'd1);
    measure(1'b1, 2, "sw_ch0_hi");
    measure(1'b0, 2, "sw_ch0_lo");
    chk("sw_active_sel", 32'(bus.active_sel), 32'd1);
    chk("sw_pending_clr", 32'(bus.pending), 32'd0);
    set_div(1, 3);
    measure(1'b1, 5, "sw_ch1_hi");
    measure(1'b0, 5, "sw_ch1_lo");

    // Stop mid-HIGH with div=3: full phases, then parked low
    bus.en = 1'b0;
    measure(1'b1, 4, "stop_hi");
    measure(1'b0, 4, "stop_lo");
    chk("stop_running", 32'(bus.running), 32'd0);
    chk("stop_clk", 32'(bus.clk_out), 32'd0);
    repeat (3) cycle();

    // div=0 gives clk/2, then an in-place retune of the same channel to 7
    bus.sel = 2'd2;
    set_div(2, 0);
    bus.en = 1'b1;
    cycle();
    measure(1'b1, 1, "d0_hi0");
    measure(1'b0, 1, "d0_lo0");
    measure(1'b1, 1, "d0_hi1");
    measure(1'b0, 1, "d0_lo1");
    set_div(2, 7);
    measure(1'b1, 1, "rt_old_hi");
    measure(1'b0, 1, "rt_old_lo");
    measure(1'b1, 8, "rt_new_hi");

    // Out-of-range select clamps to the last channel; reset mid-HIGH
    bus.sel = 2'd3;
    measure(1'b0, 8, "rt_new_lo");
    measure(1'b1, 8, "oor_hi");
    measure(1'b0, 8, "oor_lo");
    chk("oor_active_sel", 32'(bus.active_sel), 32'd2);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    chk("rst_clk", 32'(bus.clk_out), 32'd0);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_active_sel", 32'(bus.active_sel), 32'd0);
    rst = 1'b0;
    bus.en = 1'b0;
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst    = ($urandom_range(0, 99) < 2);
      bus.en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 7) == 0) bus.sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) set_div(int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
